// File: rtl/master_burst_out_port_if.sv
// Bus bundle for the burst-capable serial master output port.
// The "master" modport is the port itself; the "slave" modport is the
// surrounding upstream logic, arbiter and slave side that drive its inputs.
interface master_burst_out_port_if #(
    parameter int SLAVE_LEN = 2,
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int LANES     = 1,
    parameter int BURST_W   = 4
);
    logic [SLAVE_LEN-1:0] slave_select;
    logic [1:0]           instruction;
    logic [ADDR_LEN-1:0]  address;
    logic [DATA_LEN-1:0]  data;
    logic [BURST_W-1:0]   burst_len;
    logic                 data_req;
    logic                 tx_done;
    logic                 tx_abort;
    logic                 slave_ready;
    logic                 arbiter_busy;
    logic                 bus_busy;
    logic                 approval_grant;
    logic                 master_ready;
    logic                 approval_request;
    logic [LANES-1:0]     tx_slave_select;
    logic                 master_valid;
    logic                 write_en;
    logic                 read_en;
    logic [LANES-1:0]     tx_address;
    logic [LANES-1:0]     tx_data;

    modport master (
        input  slave_select, instruction, address, data, burst_len,
        input  slave_ready, arbiter_busy, bus_busy, approval_grant,
        output data_req, tx_done, tx_abort, master_ready, approval_request,
        output tx_slave_select, master_valid, write_en, read_en, tx_address, tx_data
    );

    modport slave (
        output slave_select, instruction, address, data, burst_len,
        output slave_ready, arbiter_busy, bus_busy, approval_grant,
        input  data_req, tx_done, tx_abort, master_ready, approval_request,
        input  tx_slave_select, master_valid, write_en, read_en, tx_address, tx_data
    );
endinterface

// File: rtl/master_burst_out_port.sv
// Serial system-bus master output port: arbitrates, shifts slave select,
// address and write-burst data out LSB chunk first on LANES-wide lines,
// and aborts when the slave handshake stalls for TIMEOUT cycles.
module master_burst_out_port #(
    parameter int SLAVE_LEN = 2,
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int LANES     = 1,
    parameter int BURST_W   = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    master_burst_out_port_if.master  bus
);
    // Chunk counts per field; top chunk of each field is zero-padded.
    localparam int S       = (SLAVE_LEN + LANES - 1) / LANES;
    localparam int A       = (ADDR_LEN + LANES - 1) / LANES;
    localparam int D       = (DATA_LEN + LANES - 1) / LANES;
    localparam int FIRST_N = (A > D) ? A : D;
    localparam int M       = (FIRST_N > S) ? FIRST_N : S;
    localparam int MAXW    = M * LANES;
    localparam int CW      = $clog2(M + 1);
    localparam int TW      = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, WAIT_ARB, TX_SELECT, WAIT_BUS, WAIT_APPROVAL, WAIT_HANDSHAKE,
        TX_FIRST, TX_BEAT, STALL, DONE, ABORT
    } state_t;

    state_t               state_r;
    logic [SLAVE_LEN-1:0] sel_r;
    logic                 rd_r;
    logic [ADDR_LEN-1:0]  addr_r;
    logic [BURST_W-1:0]   burst_r;
    logic [BURST_W-1:0]   beat_r;
    logic [DATA_LEN-1:0]  word_r;
    logic [CW-1:0]        cnt_r;
    logic [TW-1:0]        timer_r;

    logic                 data_req_r;
    logic                 tx_done_r;
    logic                 tx_abort_r;
    logic                 master_ready_r;
    logic                 approval_request_r;
    logic [LANES-1:0]     tx_slave_select_r;
    logic                 master_valid_r;
    logic                 write_en_r;
    logic                 read_en_r;
    logic [LANES-1:0]     tx_address_r;
    logic [LANES-1:0]     tx_data_r;

    logic [MAXW-1:0]      sel_ext_s;
    logic [MAXW-1:0]      addr_ext_s;
    logic [MAXW-1:0]      word_ext_s;
    logic [MAXW-1:0]      in_ext_s;
    logic [CW-1:0]        cnt_next_s;
    logic [CW-1:0]        first_last_s;
    logic                 beat_end_s;
    logic                 last_beat_s;

    // Chunk idx of a zero-extended field; chunks past the field read as zero.
    function automatic logic [LANES-1:0] chunk_at(input logic [MAXW-1:0] vec, input int idx);
        logic [LANES-1:0] res;
        res = {LANES{1'b0}};
        for (int b = 0; b < LANES; b++) begin
            if ((idx * LANES + b) < MAXW) begin
                res[b] = vec[idx * LANES + b];
            end
        end
        return res;
    endfunction

    assign sel_ext_s    = MAXW'(sel_r);
    assign addr_ext_s   = MAXW'(addr_r);
    assign word_ext_s   = MAXW'(word_r);
    assign in_ext_s     = MAXW'(bus.data);
    assign cnt_next_s   = cnt_r + CW'(1);
    assign first_last_s = rd_r ? CW'(A - 1) : CW'(FIRST_N - 1);
    assign last_beat_s  = rd_r | (beat_r == burst_r);

    // Flags the final chunk cycle of the address beat or of a data-only beat.
    always_comb begin
        beat_end_s = 1'b0;
        if (state_r == TX_FIRST) begin
            beat_end_s = (cnt_r == first_last_s);
        end else if (state_r == TX_BEAT) begin
            beat_end_s = (cnt_r == CW'(D - 1));
        end else begin
            beat_end_s = 1'b0;
        end
    end

    // Transfer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r            <= IDLE;
            sel_r              <= {SLAVE_LEN{1'b0}};
            rd_r               <= 1'b0;
            addr_r             <= {ADDR_LEN{1'b0}};
            burst_r            <= {BURST_W{1'b0}};
            beat_r             <= {BURST_W{1'b0}};
            word_r             <= {DATA_LEN{1'b0}};
            cnt_r              <= {CW{1'b0}};
            timer_r            <= {TW{1'b0}};
            data_req_r         <= 1'b0;
            tx_done_r          <= 1'b0;
            tx_abort_r         <= 1'b0;
            master_ready_r     <= 1'b1;
            approval_request_r <= 1'b0;
            tx_slave_select_r  <= {LANES{1'b0}};
            master_valid_r     <= 1'b0;
            write_en_r         <= 1'b0;
            read_en_r          <= 1'b0;
            tx_address_r       <= {LANES{1'b0}};
            tx_data_r          <= {LANES{1'b0}};
        end else begin
            data_req_r <= 1'b0;
            tx_done_r  <= 1'b0;
            tx_abort_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.instruction[1]) begin
                        sel_r              <= bus.slave_select;
                        rd_r               <= bus.instruction[0];
                        addr_r             <= bus.address;
                        burst_r            <= bus.burst_len;
                        word_r             <= bus.data;
                        beat_r             <= {BURST_W{1'b0}};
                        data_req_r         <= 1'b1;
                        master_ready_r     <= 1'b0;
                        approval_request_r <= 1'b1;
                        state_r            <= WAIT_ARB;
                    end
                end
                WAIT_ARB: begin
                    if (!bus.arbiter_busy) begin
                        cnt_r             <= {CW{1'b0}};
                        tx_slave_select_r <= chunk_at(sel_ext_s, 0);
                        state_r           <= TX_SELECT;
                    end
                end
                TX_SELECT: begin
                    if (cnt_r == CW'(S - 1)) begin
                        tx_slave_select_r  <= {LANES{1'b0}};
                        approval_request_r <= 1'b0;
                        state_r            <= bus.bus_busy ? WAIT_BUS : WAIT_APPROVAL;
                    end else begin
                        cnt_r             <= cnt_next_s;
                        tx_slave_select_r <= chunk_at(sel_ext_s, int'(cnt_next_s));
                    end
                end
                WAIT_BUS: begin
                    if (!bus.bus_busy) begin
                        state_r <= WAIT_APPROVAL;
                    end
                end
                WAIT_APPROVAL: begin
                    // A grant in the same cycle as bus_busy still wins.
                    if (bus.approval_grant) begin
                        master_valid_r <= 1'b1;
                        write_en_r     <= ~rd_r;
                        read_en_r      <= rd_r;
                        timer_r        <= {TW{1'b0}};
                        state_r        <= WAIT_HANDSHAKE;
                    end else if (bus.bus_busy) begin
                        approval_request_r <= 1'b1;
                        state_r            <= WAIT_ARB;
                    end
                end
                WAIT_HANDSHAKE, STALL: begin
                    if (bus.slave_ready) begin
                        cnt_r <= {CW{1'b0}};
                        if (state_r == WAIT_HANDSHAKE) begin
                            tx_address_r <= chunk_at(addr_ext_s, 0);
                            tx_data_r    <= rd_r ? {LANES{1'b0}} : chunk_at(word_ext_s, 0);
                            state_r      <= TX_FIRST;
                        end else begin
                            word_r       <= bus.data;
                            tx_address_r <= {LANES{1'b0}};
                            tx_data_r    <= chunk_at(in_ext_s, 0);
                            data_req_r   <= 1'b1;
                            beat_r       <= beat_r + BURST_W'(1);
                            state_r      <= TX_BEAT;
                        end
                    end else if (timer_r == TW'(TIMEOUT - 1)) begin
                        tx_abort_r     <= 1'b1;
                        master_valid_r <= 1'b0;
                        write_en_r     <= 1'b0;
                        read_en_r      <= 1'b0;
                        tx_address_r   <= {LANES{1'b0}};
                        tx_data_r      <= {LANES{1'b0}};
                        state_r        <= ABORT;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                TX_FIRST, TX_BEAT: begin
                    if (beat_end_s) begin
                        if (last_beat_s) begin
                            tx_done_r      <= 1'b1;
                            master_valid_r <= 1'b0;
                            write_en_r     <= 1'b0;
                            read_en_r      <= 1'b0;
                            tx_address_r   <= {LANES{1'b0}};
                            tx_data_r      <= {LANES{1'b0}};
                            state_r        <= DONE;
                        end else if (bus.slave_ready) begin
                            cnt_r        <= {CW{1'b0}};
                            word_r       <= bus.data;
                            tx_address_r <= {LANES{1'b0}};
                            tx_data_r    <= chunk_at(in_ext_s, 0);
                            data_req_r   <= 1'b1;
                            beat_r       <= beat_r + BURST_W'(1);
                            state_r      <= TX_BEAT;
                        end else begin
                            // Serial lines carry nothing while stalled.
                            timer_r      <= {TW{1'b0}};
                            tx_address_r <= {LANES{1'b0}};
                            tx_data_r    <= {LANES{1'b0}};
                            state_r      <= STALL;
                        end
                    end else begin
                        cnt_r        <= cnt_next_s;
                        tx_address_r <= (state_r == TX_FIRST) ? chunk_at(addr_ext_s, int'(cnt_next_s))
                                                              : {LANES{1'b0}};
                        tx_data_r    <= rd_r ? {LANES{1'b0}} : chunk_at(word_ext_s, int'(cnt_next_s));
                    end
                end
                DONE, ABORT: begin
                    master_ready_r <= 1'b1;
                    state_r        <= IDLE;
                end
                default: begin
                    master_ready_r     <= 1'b1;
                    approval_request_r <= 1'b0;
                    master_valid_r     <= 1'b0;
                    write_en_r         <= 1'b0;
                    read_en_r          <= 1'b0;
                    state_r            <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_req         = data_req_r;
    assign bus.tx_done          = tx_done_r;
    assign bus.tx_abort         = tx_abort_r;
    assign bus.master_ready     = master_ready_r;
    assign bus.approval_request = approval_request_r;
    assign bus.tx_slave_select  = tx_slave_select_r;
    assign bus.master_valid     = master_valid_r;
    assign bus.write_en         = write_en_r;
    assign bus.read_en          = read_en_r;
    assign bus.tx_address       = tx_address_r;
    assign bus.tx_data          = tx_data_r;
endmodule

// File: tb/tb_master_burst_out_port.sv
// Directed bench for master_burst_out_port with LANES=2: single write,
// burst write, read, arbitration/bus contention, timeouts and mid-burst reset.
module tb_master_burst_out_port;
    logic clk;
    logic reset;

    master_burst_out_port_if #(.SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8), .LANES(2), .BURST_W(4)) bus ();

    master_burst_out_port #(
        .SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8), .LANES(2), .BURST_W(4), .TIMEOUT(15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run;
    int tests_failed;

    logic [7:0] words [4];
    int         widx;
    int         dreq_cnt;
    int         sel_cnt;
    int         done_cnt;
    int         abort_cnt;
    logic       seen_valid;
    logic       we_seen;
    logic       re_seen;
    logic [1:0] addr_q [$];
    logic [1:0] data_q [$];
    logic [1:0] exp_a_q [$];
    logic [1:0] exp_d_q [$];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        widx = 0; dreq_cnt = 0; sel_cnt = 0; done_cnt = 0; abort_cnt = 0;
        seen_valid = 1'b0; we_seen = 1'b0; re_seen = 1'b0;
        addr_q.delete(); data_q.delete();
    endtask

    // One clock: sample at the falling edge, act as upstream on data_req.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (bus.data_req) begin
            dreq_cnt++;
            if (widx < 3) widx++;
            bus.data = words[widx];
        end
        if (bus.tx_slave_select != 2'd0) sel_cnt++;
        if (bus.tx_done)  done_cnt++;
        if (bus.tx_abort) abort_cnt++;
        if (bus.master_valid) begin
            if (!seen_valid) begin
                seen_valid = 1'b1;
                we_seen    = bus.write_en;
                re_seen    = bus.read_en;
            end else begin
                addr_q.push_back(bus.tx_address);
                data_q.push_back(bus.tx_data);
            end
        end
        if (!bus.master_ready) bus.instruction = 2'b00;
    endtask

    task automatic set_ctl(input logic arb, input logic bb, input logic gr, input logic rdy);
        bus.arbiter_busy = arb; bus.bus_busy = bb; bus.approval_grant = gr; bus.slave_ready = rdy;
    endtask

    task automatic start_xfer(input logic [1:0] sel, input logic [1:0] instr,
                              input logic [11:0] addr, input logic [3:0] burst);
        clear_stats();
        bus.slave_select = sel;
        bus.instruction  = instr;
        bus.address      = addr;
        bus.burst_len    = burst;
        bus.data         = words[0];
        tick();
    endtask

    task automatic wait_end(input string tag, input int bound);
        for (int i = 0; i < bound && done_cnt == 0 && abort_cnt == 0; i++) tick();
        check_eq({tag, " end_seen"}, 32'((done_cnt + abort_cnt) != 0), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int bound);
        for (int i = 0; i < bound && !seen_valid; i++) tick();
        check_eq({tag, " valid_seen"}, 32'(seen_valid), 32'd1);
    endtask

    task automatic compare_streams(input string tag);
        check_eq({tag, " addr_len"}, 32'(addr_q.size()), 32'(exp_a_q.size()));
        check_eq({tag, " data_len"}, 32'(data_q.size()), 32'(exp_d_q.size()));
        for (int i = 0; i < exp_a_q.size(); i++)
            check_eq($sformatf("%s addr[%0d]", tag, i), (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hDEAD, 32'(exp_a_q[i]));
        for (int i = 0; i < exp_d_q.size(); i++)
            check_eq($sformatf("%s data[%0d]", tag, i), (i < data_q.size()) ? 32'(data_q[i]) : 32'hDEAD, 32'(exp_d_q[i]));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " master_ready"}, 32'(bus.master_ready), 32'd1);
        check_eq({tag, " approval_request"}, 32'(bus.approval_request), 32'd0);
        check_eq({tag, " master_valid"}, 32'(bus.master_valid), 32'd0);
        check_eq({tag, " en"}, {30'd0, bus.write_en, bus.read_en}, 32'd0);
        check_eq({tag, " pulses"}, {29'd0, bus.data_req, bus.tx_done, bus.tx_abort}, 32'd0);
        check_eq({tag, " lines"}, {26'd0, bus.tx_slave_select, bus.tx_address, bus.tx_data}, 32'd0);
    endtask

    // Single write sel=10 addr=A5C data=3C, no contention.
    task automatic run_case1(input string tag);
        words[0] = 8'h3C; words[1] = 8'hFF; words[2] = 8'hFF; words[3] = 8'hFF;
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
        start_xfer(2'b10, 2'b10, 12'hA5C, 4'd0);
        wait_end(tag, 100);
        tick();
        exp_a_q = '{2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
        exp_d_q = '{2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
        compare_streams(tag);
        check_eq({tag, " sel_cycles"}, 32'(sel_cnt), 32'd1);
        check_eq({tag, " write_en"}, {30'd0, we_seen, re_seen}, 32'd2);
        check_eq({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
        check_eq({tag, " abort_cnt"}, 32'(abort_cnt), 32'd0);
        check_eq({tag, " dreq_cnt"}, 32'(dreq_cnt), 32'd1);
        check_eq({tag, " ready_after"}, 32'(bus.master_ready), 32'd1);
    endtask

    int n;

    initial begin
        tests_run = 0; tests_failed = 0;
        reset = 1'b1;
        bus.slave_select = 2'b00; bus.instruction = 2'b00; bus.address = 12'h000;
        bus.data = 8'h00; bus.burst_len = 4'd0;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) words[i] = 8'h00;
        clear_stats();
        tick(); tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("idle");

        // Case 1: single write.
        run_case1("wr1");

        // Case 2: burst of three words.
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'hFF;
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
        start_xfer(2'b01, 2'b10, 12'h123, 4'd2);
        wait_end("burst", 200);
        tick();
        exp_a_q = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        exp_d_q = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0};
        compare_streams("burst");
        check_eq("burst dreq_cnt", 32'(dreq_cnt), 32'd3);
        check_eq("burst done_cnt", 32'(done_cnt), 32'd1);

        // Case 3: read addr=001.
        words[0] = 8'hAA;
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
        start_xfer(2'b11, 2'b11, 12'h001, 4'd5);
        wait_end("read", 100);
        tick();
        exp_a_q = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        exp_d_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        compare_streams("read");
        check_eq("read en", {30'd0, we_seen, re_seen}, 32'd1);
        check_eq("read dreq_cnt", 32'(dreq_cnt), 32'd1);
        check_eq("read done_cnt", 32'(done_cnt), 32'd1);

        // Case 4: arbiter busy, then bus busy in WAIT_APPROVAL.
        words[0] = 8'h3C; words[1] = 8'hFF; words[2] = 8'hFF; words[3] = 8'hFF;
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1);
        start_xfer(2'b10, 2'b10, 12'hA5C, 4'd0);
        check_eq("arb dreq", 32'(bus.data_req), 32'd1);
        check_eq("arb req0", 32'(bus.approval_request), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("arb hold%0d", i), {30'd0, bus.approval_request, |bus.tx_slave_select}, 32'd2);
        end
        bus.arbiter_busy = 1'b0;
        tick();
        check_eq("arb sel1", 32'(bus.tx_slave_select), 32'd2);
        tick();
        check_eq("arb req_dropped", 32'(bus.approval_request), 32'd0);
        bus.bus_busy = 1'b1;
        tick();
        check_eq("arb req_raised", 32'(bus.approval_request), 32'd1);
        check_eq("arb no_valid", 32'(bus.master_valid), 32'd0);
        bus.bus_busy = 1'b0;
        tick();
        check_eq("arb sel2", 32'(bus.tx_slave_select), 32'd2);
        bus.approval_grant = 1'b1;
        wait_end("arb", 100);
        tick();
        exp_a_q = '{2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
        exp_d_q = '{2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
        compare_streams("arb");
        check_eq("arb sel_cycles", 32'(sel_cnt), 32'd2);
        check_eq("arb done_cnt", 32'(done_cnt), 32'd1);

        // Case 5a: handshake timeout.
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
        start_xfer(2'b10, 2'b10, 12'h0F0, 4'd0);
        wait_valid("hto", 20);
        n = 0;
        for (int i = 0; i < 40 && !bus.tx_abort; i++) begin tick(); n++; end
        check_eq("hto cycles", 32'(n), 32'd15);
        check_eq("hto valid_low", {30'd0, bus.master_valid, bus.write_en}, 32'd0);
        tick();
        check_eq("hto ready_next", {30'd0, bus.master_ready, bus.tx_abort}, 32'd2);
        check_eq("hto no_done", 32'(done_cnt), 32'd0);

        // Case 5b: stall at the boundary after the address beat.
        words[0] = 8'h55; words[1] = 8'h66;
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
        start_xfer(2'b10, 2'b10, 12'h0F0, 4'd1);
        wait_valid("sto", 20);
        for (int i = 0; i < 6; i++) tick();
        bus.slave_ready = 1'b0;
        tick();
        check_eq("sto stall_valid", {29'd0, bus.master_valid, bus.tx_abort, |bus.tx_data}, 32'd4);
        n = 1;
        for (int i = 0; i < 40 && !bus.tx_abort; i++) begin tick(); n++; end
        check_eq("sto cycles", 32'(n), 32'd16);
        check_eq("sto valid_low", 32'(bus.master_valid), 32'd0);
        check_eq("sto dreq_cnt", 32'(dreq_cnt), 32'd1);
        tick();
        check_eq("sto ready_next", 32'(bus.master_ready), 32'd1);
        check_eq("sto no_done", 32'(done_cnt), 32'd0);

        // Case 6: reset during beat 1 of a burst.
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
        start_xfer(2'b10, 2'b10, 12'h456, 4'd2);
        wait_valid("rst", 20);
        for (int i = 0; i < 7; i++) tick();
        check_eq("rst beat1_dreq", 32'(bus.data_req), 32'd1);
        reset = 1'b1;
        tick();
        check_idle("rst mid");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_eq("rst silent", 32'(done_cnt + abort_cnt), 32'd0);
        check_eq("rst ready", 32'(bus.master_ready), 32'd1);
        run_case1("wr2");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
